// File: rtl/ahb_sram_slave.sv
// ----------------------------------------------------------------------------
// ahb_sram_slave
//
// Parametrised AHB-Lite memory slave. A word-wide array with byte, halfword,
// word (and dword on a 64-bit bus) access serves as boot ROM, scratch RAM or
// program memory on the AHB interconnect. The number of wait states is
// programmable. A read-only mode is available.
//
// Parameters
//   AHB_ADDR_WIDTH  address bus width
//   AHB_DATA_WIDTH  data bus width, 32 or 64
//   MEM_DEPTH       number of AHB_DATA_WIDTH words, power of 2 (>= 2)
//   BASE_ADDR       byte address of word 0
//   WAIT_STATES     hreadyout_o low cycles per data phase, 0..15
//   READ_ONLY       non-zero: writes never modify memory
//   INIT_FILE       preload file name (not used by this implementation)
//
// Ports
//   clk          in   clock
//   rstn         in   synchronous active-low reset
//   hsel_i       in   slave select
//   haddr_i      in   byte address
//   hwdata_i     in   write data (data phase)
//   hwrite_i     in   1 = write
//   hsize_i      in   0 byte, 1 half, 2 word, 3 dword
//   hburst_i     in   ignored
//   hprot_i      in   ignored
//   htrans_i     in   IDLE / BUSY / NONSEQ / SEQ
//   hmastlock_i  in   ignored
//   hready_i     in   bus ready
//   hrdata_o     out  read data (registered)
//   hreadyout_o  out  slave ready (registered)
//   hresp_o      out  0 OKAY, 1 ERROR
//
// Build option
//   AHB_SRAM_ERR_RESP_EN  when defined, the slave answers these transfers with
//   the two-cycle AHB ERROR response (ERR1, ERR2):
//     - out-of-range transfers
//     - illegal-size transfers
//     - unaligned transfers
//     - writes while READ_ONLY is set
//   When undefined, those transfers complete as OKAY with no memory effect
//   (reads return 0), and hresp_o is tied low.
// ----------------------------------------------------------------------------
module ahb_sram_slave #(
   parameter int                        AHB_ADDR_WIDTH = 32,
   parameter int                        AHB_DATA_WIDTH = 32,
   parameter int                        MEM_DEPTH      = 1024,
   parameter logic [AHB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int                        WAIT_STATES    = 0,
   parameter int                        READ_ONLY      = 0,
   parameter string                     INIT_FILE      = ""
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      hsel_i,
   input  logic [AHB_ADDR_WIDTH-1:0] haddr_i,
   input  logic [AHB_DATA_WIDTH-1:0] hwdata_i,
   input  logic                      hwrite_i,
   input  logic [2:0]                hsize_i,
   input  logic [2:0]                hburst_i,
   input  logic [3:0]                hprot_i,
   input  logic [1:0]                htrans_i,
   input  logic                      hmastlock_i,
   input  logic                      hready_i,
   output logic [AHB_DATA_WIDTH-1:0] hrdata_o,
   output logic                      hreadyout_o,
   output logic                      hresp_o
);

   localparam int NB = AHB_DATA_WIDTH / 8;      // byte lanes
   localparam int BW = $clog2(NB);              // byte-offset bits in a word
   localparam int IW = $clog2(MEM_DEPTH);       // word index bits
   localparam logic [AHB_ADDR_WIDTH:0] MEM_BYTES = (AHB_ADDR_WIDTH+1)'(MEM_DEPTH * NB);
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam logic       RO        = (READ_ONLY != 0);

`ifdef AHB_SRAM_ERR_RESP_EN
   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_LAST, ST_ERR1, ST_ERR2} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_LAST} state_t;
`endif

   genvar gi;

   // ------------------------------------------------------------------------
   // Address-phase decode
   // ------------------------------------------------------------------------
   logic                      accept;
   logic [AHB_ADDR_WIDTH-1:0] offset;
   logic [BW-1:0]             low_bits;
   logic [BW-1:0]             size_mask;
   logic [NB-1:0]             lane_en;
   logic [IW-1:0]             addr_idx;
   logic                      in_range;
   logic                      size_ok;
   logic                      aligned;
   logic                      addr_ok;

   assign accept   = hsel_i & hready_i & htrans_i[1];
   // Addresses below BASE_ADDR wrap to huge offsets and fail the range check.
   assign offset   = haddr_i - BASE_ADDR;
   assign low_bits = offset[BW-1:0];
   assign addr_idx = offset[BW +: IW];
   assign in_range = ({1'b0, offset} < MEM_BYTES);
   assign size_ok  = (hsize_i <= 3'(BW));

   // size_mask has a one for every offset bit that must be zero for alignment.
   generate
      for (gi = 0; gi < BW; gi++) begin : g_size_mask
         assign size_mask[gi] = (hsize_i > 3'(gi));
      end
   endgenerate

   assign aligned = ((low_bits & size_mask) == '0);
   assign addr_ok = in_range & size_ok & aligned;

   // A lane is enabled when it matches the offset on every bit above the
   // transfer size. For an aligned access these are exactly the addressed
   // bytes.
   generate
      for (gi = 0; gi < NB; gi++) begin : g_lane_en
         assign lane_en[gi] = (((BW'(gi) ^ low_bits) & ~size_mask) == '0);
      end
   endgenerate

   // State taken on an accepted transfer.
   state_t acc_state;

   always_comb begin
      acc_state = (WAIT_STATES > 0) ? ST_WAIT : ST_LAST;
`ifdef AHB_SRAM_ERR_RESP_EN
      if (!addr_ok || (RO && hwrite_i)) begin
         acc_state = ST_ERR1;
      end
`endif
   end

   // ------------------------------------------------------------------------
   // Data-phase registers
   // ------------------------------------------------------------------------
   state_t          state_reg;
   logic [3:0]      cnt_reg;
   logic            write_reg;
   logic            access_ok_reg;   // transfer is legal and may touch memory
   logic [NB-1:0]   lane_reg;
   logic [IW-1:0]   idx_reg;
   logic            resp_reg;

   // ------------------------------------------------------------------------
   // Memory array
   // ------------------------------------------------------------------------
   logic [AHB_DATA_WIDTH-1:0] mem [MEM_DEPTH];
   logic                      commit;

   // A write lands at the edge that ends LAST. Reset during that cycle drops
   // it.
   assign commit = (state_reg == ST_LAST) & write_reg & access_ok_reg & ~RO & rstn;

   always_ff @(posedge clk) begin
      if (commit) begin
         for (int b = 0; b < NB; b++) begin
            if (lane_reg[b]) begin
               mem[idx_reg][b*8 +: 8] <= hwdata_i[b*8 +: 8];
            end
         end
      end
   end

   // Read port. A read is accepted back to back with the write before it. In
   // that case the write commits on the same edge that loads hrdata_o. The
   // write lanes are forwarded so that the read sees the new data.
   logic [IW-1:0]             rd_idx;
   logic [AHB_DATA_WIDTH-1:0] rd_mem;
   logic [AHB_DATA_WIDTH-1:0] rd_fwd;

   assign rd_idx = (state_reg == ST_WAIT) ? idx_reg : addr_idx;
   assign rd_mem = mem[rd_idx];

   generate
      for (gi = 0; gi < NB; gi++) begin : g_fwd
         assign rd_fwd[gi*8 +: 8] = (commit && (idx_reg == rd_idx) && lane_reg[gi])
                                    ? hwdata_i[gi*8 +: 8] : rd_mem[gi*8 +: 8];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Transfer FSM with registered bus outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         write_reg     <= 1'b0;
         access_ok_reg <= 1'b0;
         lane_reg      <= '0;
         idx_reg       <= '0;
         resp_reg      <= 1'b0;
         hreadyout_o   <= 1'b1;
         hrdata_o      <= '0;
      end else if (state_reg == ST_WAIT) begin
         if (cnt_reg == '0) begin
            state_reg   <= ST_LAST;
            hreadyout_o <= 1'b1;
            hrdata_o    <= (!write_reg && access_ok_reg) ? rd_fwd : '0;
         end else begin
            cnt_reg <= cnt_reg - 4'd1;
         end
      end
`ifdef AHB_SRAM_ERR_RESP_EN
      else if (state_reg == ST_ERR1) begin
         state_reg   <= ST_ERR2;
         hreadyout_o <= 1'b1;
         resp_reg    <= 1'b1;
         hrdata_o    <= '0;
      end
`endif
      else if (accept) begin
         // IDLE, LAST and ERR2 all take a new transfer the same way.
         state_reg     <= acc_state;
         cnt_reg       <= WAIT_LOAD;
         write_reg     <= hwrite_i;
         access_ok_reg <= addr_ok;
         lane_reg      <= lane_en;
         idx_reg       <= addr_idx;
         hreadyout_o   <= (acc_state == ST_LAST);
`ifdef AHB_SRAM_ERR_RESP_EN
         resp_reg      <= (acc_state == ST_ERR1);
`else
         resp_reg      <= 1'b0;
`endif
         hrdata_o      <= ((acc_state == ST_LAST) && !hwrite_i && addr_ok) ? rd_fwd : '0;
      end else begin
         state_reg     <= ST_IDLE;
         write_reg     <= 1'b0;
         access_ok_reg <= 1'b0;
         resp_reg      <= 1'b0;
         hreadyout_o   <= 1'b1;
         hrdata_o      <= '0;
      end
   end

`ifdef AHB_SRAM_ERR_RESP_EN
   assign hresp_o = resp_reg;
`else
   assign hresp_o = 1'b0;
   logic unused_resp;
   assign unused_resp = resp_reg;
`endif

   // These inputs carry no meaning for a plain memory slave.
   logic unused_inputs;
   assign unused_inputs = ^{hburst_i, hprot_i, hmastlock_i, htrans_i[0]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// ----------------------------------------------------------------------------
// tb_ahb_sram_slave
//
// Directed bench for ahb_sram_slave. It builds three slaves, and each one is
// the only slave on its own bus:
//   index 0: zero wait states, read/write
//   index 1: two wait states, read/write
//   index 2: zero wait states, read-only (array preloaded through hierarchy)
// Address, control and write data are shared. hsel picks the target.
// ----------------------------------------------------------------------------
module tb_ahb_sram_slave;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic [2:0]  sel;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [1:0]  htrans;
   logic [2:0]  ready_v;
   logic [2:0]  resp_v;
   logic [31:0] rdata_v [3];

   int checks = 0;
   int errors = 0;

`ifdef AHB_SRAM_ERR_RESP_EN
   localparam int ERR_WAITS = 1;
   localparam int ERR_RESP  = 2;
`else
   localparam int ERR_WAITS = 0;
   localparam int ERR_RESP  = 0;
`endif

   ahb_sram_slave #(
      .AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32), .MEM_DEPTH(64),
      .BASE_ADDR(32'h0), .WAIT_STATES(0), .READ_ONLY(0), .INIT_FILE("")
   ) dut_ws0 (
      .clk(clk), .rstn(rstn), .hsel_i(sel[0]), .haddr_i(haddr), .hwdata_i(hwdata),
      .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(3'b000), .hprot_i(4'b0011),
      .htrans_i(htrans), .hmastlock_i(1'b0), .hready_i(ready_v[0]),
      .hrdata_o(rdata_v[0]), .hreadyout_o(ready_v[0]), .hresp_o(resp_v[0])
   );

   ahb_sram_slave #(
      .AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32), .MEM_DEPTH(64),
      .BASE_ADDR(32'h0), .WAIT_STATES(2), .READ_ONLY(0), .INIT_FILE("")
   ) dut_ws2 (
      .clk(clk), .rstn(rstn), .hsel_i(sel[1]), .haddr_i(haddr), .hwdata_i(hwdata),
      .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(3'b000), .hprot_i(4'b0011),
      .htrans_i(htrans), .hmastlock_i(1'b0), .hready_i(ready_v[1]),
      .hrdata_o(rdata_v[1]), .hreadyout_o(ready_v[1]), .hresp_o(resp_v[1])
   );

   ahb_sram_slave #(
      .AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32), .MEM_DEPTH(64),
      .BASE_ADDR(32'h0), .WAIT_STATES(0), .READ_ONLY(1), .INIT_FILE("")
   ) dut_ro (
      .clk(clk), .rstn(rstn), .hsel_i(sel[2]), .haddr_i(haddr), .hwdata_i(hwdata),
      .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(3'b000), .hprot_i(4'b0011),
      .htrans_i(htrans), .hmastlock_i(1'b0), .hready_i(ready_v[2]),
      .hrdata_o(rdata_v[2]), .hreadyout_o(ready_v[2]), .hresp_o(resp_v[2])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One non-pipelined transfer to slave t. The transfer starts with the
   // slave idle. The task returns the read data sampled in the last data-phase
   // cycle, the number of cycles with hreadyout low, and the number of
   // data-phase cycles with hresp high.
   task automatic xfer(input int t, input logic wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata,
                       output logic [31:0] rdata, output int waits, output int resp_cnt);
      int guard;
      sel       = '0;
      sel[t]    = 1'b1;
      htrans    = 2'b10;
      hwrite    = wr;
      haddr     = addr;
      hsize     = size;
      @(posedge clk); #1;
      sel       = '0;
      htrans    = 2'b00;
      hwrite    = 1'b0;
      hwdata    = wdata;
      waits     = 0;
      resp_cnt  = 0;
      guard     = 0;
      while (ready_v[t] !== 1'b1 && guard < 32) begin
         if (resp_v[t] === 1'b1) resp_cnt++;
         waits++;
         guard++;
         @(posedge clk); #1;
      end
      if (guard >= 32) check("xfer_timeout", 32'(guard), 32'd0);
      if (resp_v[t] === 1'b1) resp_cnt++;
      rdata = rdata_v[t];
      @(posedge clk); #1;
      hwdata = '0;
   endtask

   logic [31:0] rd;
   int          w;
   int          r;

   initial begin
      dut_ro.mem[0] = 32'h0BADF00D;
      rstn   = 1'b0;
      sel    = '0;
      haddr  = '0;
      hwdata = '0;
      hwrite = 1'b0;
      hsize  = 3'd2;
      htrans = 2'b00;
      repeat (3) @(posedge clk);
      #1;

      // Reset state of all three slaves.
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset_ready%0d", k), 32'(ready_v[k]), 32'd1);
         check($sformatf("reset_resp%0d", k),  32'(resp_v[k]),  32'd0);
         check($sformatf("reset_rdata%0d", k), rdata_v[k],      32'd0);
      end
      rstn = 1'b1;
      @(posedge clk); #1;

      // Pipelined write DEADBEEF @0x10 with the read of 0x10 directly behind it.
      sel = 3'b001; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
      @(posedge clk); #1;
      check("pipe1_wr_ready", 32'(ready_v[0]), 32'd1);
      hwdata = 32'hDEADBEEF; hwrite = 1'b0; haddr = 32'h10;
      @(posedge clk); #1;
      check("pipe1_rd_ready", 32'(ready_v[0]), 32'd1);
      check("pipe1_rd_data",  rdata_v[0],      32'hDEADBEEF);
      sel = '0; htrans = 2'b00; hwdata = '0;
      @(posedge clk); #1;
      check("idle_rdata_zero", rdata_v[0], 32'd0);

      // Byte write AB at 0x13, then a word read of 0x10.
      xfer(0, 1'b1, 32'h13, 3'd0, 32'hAB000000, rd, w, r);
      check("byte_wr_waits", 32'(w), 32'd0);
      xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, w, r);
      check("byte_rd_data", rd, 32'hABADBEEF);

      // Halfword write at 0x12. Lanes 0-1 of the write bus hold junk.
      xfer(0, 1'b1, 32'h12, 3'd1, 32'h1234CAFE, rd, w, r);
      xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, w, r);
      check("half_rd_data", rd, 32'h1234BEEF);

      // Pipelined write 0x1234 @0x20 with the read directly behind it.
      sel = 3'b001; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h20; hsize = 3'd2;
      @(posedge clk); #1;
      hwdata = 32'h00001234; hwrite = 1'b0;
      @(posedge clk); #1;
      check("pipe2_rd_data", rdata_v[0], 32'h00001234);
      sel = '0; htrans = 2'b00; hwdata = '0;
      @(posedge clk); #1;

      // Out of range: the write at 0x100 must not alias word 0.
      xfer(0, 1'b1, 32'h0, 3'd2, 32'h0BADF00D, rd, w, r);
      xfer(0, 1'b1, 32'h100, 3'd2, 32'hFFFFFFFF, rd, w, r);
      check("oor_wr_waits", 32'(w), 32'(ERR_WAITS));
      check("oor_wr_resp",  32'(r), 32'(ERR_RESP));
      xfer(0, 1'b0, 32'h0, 3'd2, 32'h0, rd, w, r);
      check("oor_no_alias", rd, 32'h0BADF00D);
      xfer(0, 1'b0, 32'h100, 3'd2, 32'h0, rd, w, r);
      check("oor_rd_data", rd, 32'd0);
      check("oor_rd_resp", 32'(r), 32'(ERR_RESP));

      // Unaligned word write, and a dword read that is too wide for the bus.
      xfer(0, 1'b1, 32'h22, 3'd2, 32'hFFFFFFFF, rd, w, r);
      check("unal_wr_resp", 32'(r), 32'(ERR_RESP));
      xfer(0, 1'b0, 32'h20, 3'd2, 32'h0, rd, w, r);
      check("unal_mem_kept", rd, 32'h00001234);
      xfer(0, 1'b0, 32'h20, 3'd3, 32'h0, rd, w, r);
      check("wide_rd_data", rd, 32'd0);

      // Two wait states: hreadyout low exactly two cycles per data phase.
      xfer(1, 1'b1, 32'h40, 3'd2, 32'h55667788, rd, w, r);
      check("ws2_wr_waits", 32'(w), 32'd2);
      xfer(1, 1'b0, 32'h40, 3'd2, 32'h0, rd, w, r);
      check("ws2_rd_waits", 32'(w), 32'd2);
      check("ws2_rd_data",  rd,     32'h55667788);

      // Read-only slave: the write is refused and the preloaded word survives.
      xfer(2, 1'b1, 32'h0, 3'd2, 32'hFFFFFFFF, rd, w, r);
      check("ro_wr_waits", 32'(w), 32'(ERR_WAITS));
      check("ro_wr_resp",  32'(r), 32'(ERR_RESP));
      xfer(2, 1'b0, 32'h0, 3'd2, 32'h0, rd, w, r);
      check("ro_rd_data", rd, 32'h0BADF00D);
      check("ro_rd_resp", 32'(r), 32'd0);

      // Reset during a WAIT data phase drops the write.
      sel = 3'b010; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h40; hsize = 3'd2;
      @(posedge clk); #1;
      check("rst_wait_ready", 32'(ready_v[1]), 32'd0);
      sel = '0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h11111111;
      rstn = 1'b0;
      @(posedge clk); #1;
      check("rst_after_ready", 32'(ready_v[1]), 32'd1);
      check("rst_after_resp",  32'(resp_v[1]),  32'd0);
      check("rst_after_rdata", rdata_v[1],      32'd0);
      rstn = 1'b1; hwdata = '0;
      @(posedge clk); #1;
      xfer(1, 1'b0, 32'h40, 3'd2, 32'h0, rd, w, r);
      check("rst_no_commit", rd, 32'h55667788);
      xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, w, r);
      check("rst_mem_kept", rd, 32'h1234BEEF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
